// File: rtl/vx_credit_return_if.sv
// Credit return channel between consumer-side tracker and producer.
// The master offers batched credits; the slave accepts them with ready.
interface vx_credit_return_if #(
  parameter int W = 1
);
  logic         credit_valid;
  logic         credit_ready;
  logic [W-1:0] credit_count;

  modport master (
    output credit_valid,
    output credit_count,
    input  credit_ready
  );

  modport slave (
    input  credit_valid,
    input  credit_count,
    output credit_ready
  );
endinterface

// File: rtl/vx_credit_return.sv
// Consumer-side credit batcher: counts drained entries and returns them
// to the producer in batches, with timeout and flush for partial batches.
module vx_credit_return #(
  parameter int SIZE    = 1,
  parameter int BATCH   = 1,
  parameter int TIMEOUT = 0,
  parameter int CNTW    = $clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pop,
  input  logic            flush,
  vx_credit_return_if.master cr,
  output logic [CNTW-1:0] pending,
  output logic            idle
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] SIZE_C  = CNTW'(SIZE);
  localparam logic [CNTW-1:0] BATCH_C = CNTW'(BATCH);
  localparam logic [TW-1:0]   TLAST   =
    TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CNTW-1:0] acc_q;
  logic [CNTW-1:0] snap_q;
  logic [TW-1:0]   timer_q;

  logic            fire;
  logic            pop_ok;
  logic [CNTW-1:0] acc_d;
  logic            tmo;
  logic            full_b;

  always_comb begin
    fire   = (state_q == SEND) && cr.credit_ready;
    // A pop into a full counter with no return draining it is dropped.
    pop_ok = pop && (fire || (acc_q != SIZE_C));
    acc_d  = acc_q - (fire ? snap_q : '0) + {{(CNTW-1){1'b0}}, pop_ok};
    tmo    = (TIMEOUT != 0) && (timer_q == TLAST);
    full_b = (acc_d >= BATCH_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      snap_q  <= '0;
      timer_q <= '0;
    end else begin
      acc_q <= acc_d;
      unique case (state_q)
        IDLE: begin
          if (full_b) begin
            state_q <= SEND;
            snap_q  <= acc_d;
          end else if (acc_d != '0) begin
            state_q <= ACCUM;
            timer_q <= '0;
          end
        end
        ACCUM: begin
          if (full_b || flush || tmo) begin
            state_q <= SEND;
            snap_q  <= acc_d;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        SEND: begin
          if (fire) begin
            if (full_b || (flush && acc_d != '0)) begin
              snap_q <= acc_d;
            end else if (acc_d != '0) begin
              state_q <= ACCUM;
              timer_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cr.credit_valid = (state_q == SEND);
  assign cr.credit_count = snap_q;
  assign pending         = acc_q;
  assign idle            = (state_q == IDLE);

  ovf_a: assert property (
    @(posedge clk) disable iff (reset)
    !(pop && (acc_q == SIZE_C) && !fire)
  );

endmodule

// File: doc/vx_credit_return.md
Name: VX_credit_return

Overview:
- Consumer-side counterpart of the producer's pending-size tracker.
- Counts entries drained from a SIZE-deep downstream buffer (pop) and returns them to the producer as batched credits over a valid/ready channel.
- Batching reduces return traffic. A timeout and a flush input guarantee that partial batches drain.
- Sits next to the consumer buffer. Its credit_valid/credit_count feed the producer's pop/size-decrement path.

Parameters:
- SIZE, 1, total credits = downstream buffer depth; max credits ever owed.
- BATCH, 1, owed count at or above which a return is issued immediately; 1 <= BATCH <= SIZE.
- TIMEOUT, 0, cycles a partial batch may wait in ACCUM before forced return; 0 disables the timer (flush only).
- CNTW, $clog2(SIZE+1), width of count outputs.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pop  input  1  one buffer entry drained this cycle; owes one credit.
- flush  input  1  force return of all owed credits as soon as possible.
- credit_valid  output  1  credit return offered.
- credit_ready  input  1  producer accepts the return; fire = credit_valid && credit_ready.
- credit_count  output  CNTW  credits carried by the current return; stable while valid && !ready.
- pending  output  CNTW  credits owed and not yet returned; includes any in-flight snapshot.
- idle  output  1  state == IDLE (pending == 0, no return outstanding).

Behaviour:
- Reset (async, takes effect without a clock edge):
  - state = IDLE; acc = 0; snap = 0; timer = 0.
  - credit_valid = 0; credit_count = 0; pending = 0; idle = 1.
  - Reset asserted mid-operation discards all owed credits and any unaccepted return. credit_valid drops immediately.
- Registers:
  - acc[CNTW] = owed credits.
  - snap[CNTW] = value driven on credit_count.
  - timer[max(1,$clog2(TIMEOUT+1))].
  - 2-bit state.
- pending = acc; credit_count = snap; credit_valid = (state == SEND).
- acc_next (non-SEND or no fire) = acc + pop.
- acc_next (fire) = acc - snap + pop. Widths stay CNTW; the result never underflows because snap <= acc.
- pop when acc == SIZE and no fire this cycle: assertion fails and the pop is dropped (acc unchanged).
- The return decision uses acc_next as the candidate. One registered cycle of latency: a pop at cycle N is visible on credit_valid no earlier than N+1.
- IDLE:
  - acc_next >= BATCH -> SEND, snap = acc_next.
  - else acc_next > 0 -> ACCUM, timer = 0.
  - else stay in IDLE; flush is ignored when nothing is owed.
- ACCUM:
  - acc_next >= BATCH, or flush, or (TIMEOUT != 0 && timer == TIMEOUT-1) -> SEND, snap = acc_next.
  - else timer += 1.
- SEND, no fire:
  - Hold snap and credit_valid.
  - acc += pop, so pending may grow beyond snap.
  - flush has no additional effect.
- SEND, fire:
  - acc_next >= BATCH -> stay in SEND with new snap = acc_next (back-to-back returns, valid stays high).
  - else acc_next > 0 -> ACCUM, timer = 0. A flush latched on the same cycle goes straight to SEND with snap = acc_next.
  - else -> IDLE.
- snap is always >= 1 in SEND and <= SIZE.
- The sum of fired credit_count values plus the final pending equals the total accepted pops.
- BATCH == 1: every pop produces a return on the next cycle unless a return is already stalled in SEND.

Test Plan:
1. SIZE=8, BATCH=4, TIMEOUT=16, ready=1; pop high on cycles 0-3 -> credit_valid=1, credit_count=4 at cycle 4; fires; cycle 5: pending=0, idle=1.
2. Same config; pop on cycles 0-1, then idle -> ACCUM at cycle 2 with pending=2; credit_valid rises 16 cycles later with credit_count=2; fire returns to IDLE.
3. Backpressure: reach SEND with count 4, hold ready=0, pop 3 more cycles -> credit_count stays 4 and pending=7; ready=1 -> fire, next cycle ACCUM with pending=3, credit_valid=0.
4. Back-to-back: in SEND with snap=4, acc=7, ready=1 and pop=1 on the fire cycle -> acc_next=4 >= BATCH; credit_valid stays high with credit_count=4.
5. TIMEOUT=0, BATCH=4: single pop, wait 100 cycles -> no return. Pulse flush -> next cycle credit_valid=1, credit_count=1. Flush in IDLE -> no response.
6. Assert reset asynchronously between clock edges while credit_valid=1 and pending=5 -> credit_valid=0, pending=0, idle=1 before the next edge. After deassert, one pop with BATCH=1 -> credit_count=1.
